// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the fetch stage.
//               - PC_SRC_* : next-PC source encodings from the hazard unit
//               - fetch_state_t : fetch FSM states
//               - NOP_INSTR_DEFAULT / RESET_PC_DEFAULT : default parameters
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // request outstanding / streaming
        S_HOLD = 2'd1,  // response parked in skid while decode stalls
        S_DROP = 2'd2   // waiting out a stale request after a redirect
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_1000;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_gen
// Description : Combinational next-PC generation and redirect decode.
//   i_pc              current PC
//   i_pc_src          next-PC source select
//   i_f_flush         hazard-unit flush
//   i_branch_target   branch redirect address
//   i_jump_target     jump redirect address
//   o_pc_plus4        sequential PC (mod 2^XLEN)
//   o_redirect        flush qualified by a branch/jump pc_src
//   o_redirect_target address selected by pc_src
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [1:0]      i_pc_src,
    input  logic            i_f_flush,
    input  logic [XLEN-1:0] i_branch_target,
    input  logic [XLEN-1:0] i_jump_target,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_target
);

    assign o_pc_plus4 = i_pc + XLEN'(4);

    always_comb begin
        o_redirect        = 1'b0;
        o_redirect_target = o_pc_plus4;
        case (i_pc_src)
            PC_SRC_BRANCH: begin
                o_redirect        = i_f_flush;
                o_redirect_target = i_branch_target;
            end
            PC_SRC_JUMP: begin
                o_redirect        = i_f_flush;
                o_redirect_target = i_jump_target;
            end
            default: begin
                o_redirect        = 1'b0;
                o_redirect_target = o_pc_plus4;
            end
        endcase
    end

endmodule : fetch_pc_gen
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : PC register, instruction-memory request handshake and F/D
//               pipeline register. A skid register parks a response that
//               arrives while decode is stalled; responses made stale by a
//               redirect are dropped.
// Ports       :
//   clock, reset_n                      clock / async active-low reset
//   f_stall, f_flush, pc_src            hazard-unit controls
//   branch_target, jump_target          redirect addresses
//   imem_req, imem_addr                 fetch request
//   imem_ready, imem_rdata              fetch response
//   d_valid, d_instr, d_pc, d_pc_plus4  F/D register to decode
//   f_busy                              request pending without response
//   perf_fetch_cnt, perf_stall_cnt,
//   perf_drop_cnt                       only with FETCH_PERF_CNT_EN defined
// Config      : FETCH_PERF_CNT_EN adds saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int             XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT),
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEFAULT)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            f_stall,
    input  logic            f_flush,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            d_valid,
    output logic [XLEN-1:0] d_instr,
    output logic [XLEN-1:0] d_pc,
    output logic [XLEN-1:0] d_pc_plus4,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_drop_cnt,
`endif
    output logic            f_busy
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_redir_pc;
    logic [XLEN-1:0] r_skid;
    logic            r_skid_valid;
    logic            r_d_valid;
    logic [XLEN-1:0] r_d_instr;
    logic [XLEN-1:0] r_d_pc;
    logic [XLEN-1:0] r_d_pc_plus4;

    logic [XLEN-1:0] w_pc_plus4;
    logic            w_redirect;
    logic [XLEN-1:0] w_redirect_target;

    logic            w_fd_load_mem;
    logic            w_fd_load_skid;
    logic            w_fd_bubble;
    logic            w_pc_we;
    logic [XLEN-1:0] w_pc_d;
    logic            w_skid_we;
    logic            w_skid_clr;
    logic            w_redir_we;
    logic            w_drop;

    fetch_pc_gen #(
        .XLEN (XLEN)
    ) u_pc_gen (
        .i_pc              (r_pc),
        .i_pc_src          (pc_src),
        .i_f_flush         (f_flush),
        .i_branch_target   (branch_target),
        .i_jump_target     (jump_target),
        .o_pc_plus4        (w_pc_plus4),
        .o_redirect        (w_redirect),
        .o_redirect_target (w_redirect_target)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath controls. Flush outranks stall everywhere.
    // A non-redirect flush only squashes F/D; a response accepted in that
    // cycle is discarded and the same PC is fetched again so nothing is lost.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_fd_load_mem  = 1'b0;
        w_fd_load_skid = 1'b0;
        w_fd_bubble    = 1'b0;
        w_pc_we        = 1'b0;
        w_pc_d         = w_pc_plus4;
        w_skid_we      = 1'b0;
        w_skid_clr     = 1'b0;
        w_redir_we     = 1'b0;
        w_drop         = 1'b0;
        imem_req       = 1'b0;

        case (r_state)
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (f_flush) begin
                        w_drop      = 1'b1;
                        w_fd_bubble = 1'b1;
                        if (w_redirect) begin
                            w_pc_we = 1'b1;
                            w_pc_d  = w_redirect_target;
                        end
                    end else if (f_stall) begin
                        w_skid_we    = 1'b1;
                        w_state_next = S_HOLD;
                    end else begin
                        w_fd_load_mem = 1'b1;
                        w_pc_we       = 1'b1;
                    end
                end else begin
                    if (f_flush) begin
                        w_fd_bubble = 1'b1;
                        if (w_redirect) begin
                            // Request cannot be withdrawn: remember the
                            // target and wait for the stale response.
                            w_redir_we   = 1'b1;
                            w_state_next = S_DROP;
                        end
                    end else if (!f_stall) begin
                        w_fd_bubble = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (f_flush) begin
                    w_fd_bubble = 1'b1;
                    if (w_redirect) begin
                        w_skid_clr   = 1'b1;
                        w_drop       = 1'b1;
                        w_pc_we      = 1'b1;
                        w_pc_d       = w_redirect_target;
                        w_state_next = S_REQ;
                    end
                end else if (!f_stall) begin
                    w_fd_load_skid = 1'b1;
                    w_skid_clr     = 1'b1;
                    w_pc_we        = 1'b1;
                    w_state_next   = S_REQ;
                end
            end

            S_DROP: begin
                imem_req = 1'b1;
                if (f_flush) begin
                    w_fd_bubble = 1'b1;
                end
                if (w_redirect) begin
                    w_redir_we = 1'b1;
                end
                if (imem_ready) begin
                    // A redirect arriving with the response is the latest.
                    w_drop       = 1'b1;
                    w_pc_we      = 1'b1;
                    w_pc_d       = w_redirect ? w_redirect_target : r_redir_pc;
                    w_state_next = S_REQ;
                end
            end

            default: begin
                w_state_next = S_REQ;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC, redirect and skid registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc         <= RESET_PC;
            r_redir_pc   <= '0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_pc_we) begin
                r_pc <= w_pc_d;
            end
            if (w_redir_we) begin
                r_redir_pc <= w_redirect_target;
            end
            if (w_skid_we) begin
                r_skid       <= imem_rdata;
                r_skid_valid <= 1'b1;
            end else if (w_skid_clr) begin
                r_skid_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // F/D pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_d_valid    <= 1'b0;
            r_d_instr    <= NOP_INSTR;
            r_d_pc       <= '0;
            r_d_pc_plus4 <= '0;
        end else if (w_fd_bubble) begin
            r_d_valid <= 1'b0;
        end else if (w_fd_load_mem) begin
            r_d_valid    <= 1'b1;
            r_d_instr    <= imem_rdata;
            r_d_pc       <= r_pc;
            r_d_pc_plus4 <= w_pc_plus4;
        end else if (w_fd_load_skid) begin
            r_d_valid    <= r_skid_valid;
            r_d_instr    <= r_skid;
            r_d_pc       <= r_pc;
            r_d_pc_plus4 <= w_pc_plus4;
        end
    end

    assign imem_addr  = {r_pc[XLEN-1:2], 2'b00};
    assign f_busy     = imem_req & ~imem_ready;
    assign d_valid    = r_d_valid;
    assign d_instr    = r_d_valid ? r_d_instr : NOP_INSTR;
    assign d_pc       = r_d_pc;
    assign d_pc_plus4 = r_d_pc_plus4;

`ifdef FETCH_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic w_fetch_evt;

    assign w_fetch_evt = w_fd_load_mem | (w_fd_load_skid & r_skid_valid);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (w_fetch_evt && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (f_stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (w_drop && (perf_drop_cnt != 32'hFFFF_FFFF)) begin
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
            end
        end
    end
`endif

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage: streaming,
//               decode stall with skid, redirect during a pending request,
//               flush+stall collision, PC wrap/alignment, async reset.
//               Perf counters are checked when FETCH_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        f_stall;
    logic        f_flush;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        d_valid;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pc_plus4;
    logic        f_busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] c_key = 32'hA5A5_0000;
    localparam logic [31:0] c_nop = 32'h0000_0013;

    always #5 clock = ~clock;

    // Memory model: data word is a function of the address.
    assign imem_rdata = imem_addr ^ c_key;

    fetch_stage u_dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .f_stall       (f_stall),
        .f_flush       (f_flush),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .d_valid       (d_valid),
        .d_instr       (d_instr),
        .d_pc          (d_pc),
        .d_pc_plus4    (d_pc_plus4),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt),
        .perf_drop_cnt (perf_drop_cnt),
`endif
        .f_busy        (f_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        f_stall       = 1'b0;
        f_flush       = 1'b0;
        pc_src        = 2'b00;
        branch_target = '0;
        jump_target   = '0;
        imem_ready    = 1'b1;

        // ---------------- reset state ----------------
        #12;
        check("rst_addr",   imem_addr,  32'h0000_1000);
        check("rst_valid",  {31'd0, d_valid}, 32'd0);
        check("rst_instr",  d_instr,    c_nop);
        check("rst_pc",     d_pc,       32'd0);
        check("rst_pc4",    d_pc_plus4, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;

        // ---------------- 1: streaming ----------------
        check("s1_addr0", imem_addr, 32'h0000_1000);
        tick();
        check("s1_addr1",  imem_addr, 32'h0000_1004);
        check("s1_dpc0",   d_pc,      32'h0000_1000);
        check("s1_dpc4_0", d_pc_plus4, 32'h0000_1004);
        check("s1_instr0", d_instr,   32'hA5A5_1000);
        check("s1_valid0", {31'd0, d_valid}, 32'd1);
        tick();
        check("s1_addr2", imem_addr, 32'h0000_1008);
        check("s1_dpc1",  d_pc,      32'h0000_1004);

        // ---------------- 2: decode stall ----------------
        f_stall = 1'b1;
        tick();
        check("s2_req_hold", {31'd0, imem_req}, 32'd0);
        check("s2_dpc_hold", d_pc, 32'h0000_1004);
        tick();
        tick();
        check("s2_req_hold3", {31'd0, imem_req}, 32'd0);
        check("s2_dpc_hold3", d_pc, 32'h0000_1004);
        f_stall = 1'b0;
        tick();
        check("s2_dpc_rel",   d_pc,      32'h0000_1008);
        check("s2_instr_rel", d_instr,   32'hA5A5_1008);
        check("s2_addr_next", imem_addr, 32'h0000_100C);
        check("s2_req_next",  {31'd0, imem_req}, 32'd1);
        tick();
        check("s2_dpc_100c", d_pc,      32'h0000_100C);
        check("s2_addr_1010", imem_addr, 32'h0000_1010);

        // ---------------- 3: redirect while memory busy ----------------
        imem_ready    = 1'b0;
        f_flush       = 1'b1;
        pc_src        = 2'b01;
        branch_target = 32'h0000_2000;
        #1;
        check("s3_busy", {31'd0, f_busy}, 32'd1);
        tick();
        f_flush = 1'b0;
        pc_src  = 2'b00;
        check("s3_addr_a",  imem_addr, 32'h0000_1010);
        check("s3_valid_a", {31'd0, d_valid}, 32'd0);
        check("s3_instr_a", d_instr, c_nop);
        tick();
        check("s3_addr_b",  imem_addr, 32'h0000_1010);
        check("s3_req_b",   {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        tick();
        check("s3_addr_tgt", imem_addr, 32'h0000_2000);
        check("s3_valid_c",  {31'd0, d_valid}, 32'd0);
        tick();
        check("s3_dpc_tgt",   d_pc, 32'h0000_2000);
        check("s3_valid_tgt", {31'd0, d_valid}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
        check("perf_drop",  perf_drop_cnt,  32'd1);
        check("perf_stall", perf_stall_cnt, 32'd3);
        check("perf_fetch", perf_fetch_cnt, 32'd5);
`endif

        // ---------------- 4: flush and stall together ----------------
        f_flush     = 1'b1;
        f_stall     = 1'b1;
        pc_src      = 2'b10;
        jump_target = 32'h0000_3000;
        tick();
        f_flush = 1'b0;
        f_stall = 1'b0;
        pc_src  = 2'b00;
        check("s4_valid", {31'd0, d_valid}, 32'd0);
        check("s4_addr",  imem_addr, 32'h0000_3000);
        tick();
        check("s4_dpc", d_pc, 32'h0000_3000);

        // ---------------- PC wrap and target alignment ----------------
        f_flush     = 1'b1;
        pc_src      = 2'b10;
        jump_target = 32'hFFFF_FFFE;
        tick();
        f_flush = 1'b0;
        pc_src  = 2'b00;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_dpc",   d_pc,       32'hFFFF_FFFE);
        check("wrap_dpc4",  d_pc_plus4, 32'h0000_0002);
        check("wrap_instr", d_instr,    32'h5A5A_FFFC);
        check("wrap_addr0", imem_addr,  32'h0000_0000);

        // ---------------- flush with reserved pc_src: squash only ----------------
        tick();
        check("sq_pre_addr", imem_addr, 32'h0000_0004);
        f_flush = 1'b1;
        pc_src  = 2'b11;
        tick();
        f_flush = 1'b0;
        pc_src  = 2'b00;
        check("sq_valid", {31'd0, d_valid}, 32'd0);
        check("sq_addr",  imem_addr, 32'h0000_0004);

        // ---------------- 5: async reset mid-drop ----------------
        imem_ready    = 1'b0;
        f_flush       = 1'b1;
        pc_src        = 2'b01;
        branch_target = 32'h0000_4000;
        tick();
        f_flush = 1'b0;
        pc_src  = 2'b00;
        check("s5_in_drop", imem_addr, 32'h0000_0004);
        #3;
        reset_n = 1'b0;
        #1;
        check("s5_addr",  imem_addr,  32'h0000_1000);
        check("s5_valid", {31'd0, d_valid}, 32'd0);
        check("s5_instr", d_instr,    c_nop);
        check("s5_pc",    d_pc,       32'd0);
        check("s5_pc4",   d_pc_plus4, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("s5_perf_fetch", perf_fetch_cnt, 32'd0);
        check("s5_perf_drop",  perf_drop_cnt,  32'd0);
`endif
        @(negedge clock);
        imem_ready = 1'b1;
        reset_n    = 1'b1;
        #1;
        check("s5_rel_addr", imem_addr, 32'h0000_1000);
        tick();
        check("s5_rel_dpc",  d_pc,      32'h0000_1000);
        check("s5_rel_next", imem_addr, 32'h0000_1004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
